// File: rtl/dpram_be_init.sv
// Simple-dual-port RAM with per-byte write enables, registered read, write-first
// forwarding and a post-reset zeroing sweep. Define DPRAM_PARITY_EN for per-lane parity.
module dpram_be_init #(
    parameter int ADDRW = 5,
    parameter int DATAW = 32,
    parameter int BYTEW = 8,
    localparam int LANES = DATAW / BYTEW
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [ADDRW-1:0] raddr,
    input  logic             rd_en,
    output logic [DATAW-1:0] dataout,
    output logic             dataout_valid,
    input  logic [ADDRW-1:0] waddr,
    input  logic [DATAW-1:0] datain,
    input  logic             we,
    input  logic [LANES-1:0] be,
    input  logic [LANES-1:0] wr_par_flip,
    output logic [LANES-1:0] parity_err,
    output logic             init_busy
);

    localparam int DEPTH = 1 << ADDRW;

    if (DATAW % BYTEW != 0) begin : g_width_check
        $error("dpram_be_init: DATAW must be a multiple of BYTEW");
    end

    typedef enum logic {ST_INIT, ST_RUN} state_t;

    state_t           state_q, state_d;
    logic [ADDRW-1:0] cnt_q, cnt_d;

    logic [ADDRW-1:0] mem_addr;
    logic [DATAW-1:0] mem_wdata;
    logic [LANES-1:0] mem_lane_en;
    logic [LANES-1:0] mem_flip;

    logic [DATAW-1:0] mem [DEPTH];

    logic [DATAW-1:0] rd_word_d;
    logic [LANES-1:0] perr_d;
    logic             fwd;
    logic [DATAW-1:0] dataout_q;
    logic             valid_q;
    logic [LANES-1:0] perr_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_INIT;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        if (state_q == ST_INIT) begin
            cnt_d = cnt_q + 1'b1;
            if (cnt_q == {ADDRW{1'b1}}) begin
                state_d = ST_RUN;
            end
        end
    end

    // The sweep takes over the write port; user write/flip inputs are masked.
    always_comb begin
        init_busy   = (state_q == ST_INIT);
        mem_addr    = waddr;
        mem_wdata   = datain;
        mem_lane_en = we ? be : '0;
        mem_flip    = wr_par_flip;
        if (state_q == ST_INIT) begin
            mem_addr    = cnt_q;
            mem_wdata   = '0;
            mem_lane_en = '1;
            mem_flip    = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            for (int i = 0; i < LANES; i++) begin
                if (mem_lane_en[i]) begin
                    mem[mem_addr][i*BYTEW +: BYTEW] <= mem_wdata[i*BYTEW +: BYTEW];
                end
            end
        end
    end

    assign fwd = we && (state_q == ST_RUN) && (waddr == raddr);

    always_comb begin
        rd_word_d = mem[raddr];
        for (int i = 0; i < LANES; i++) begin
            if (fwd && be[i]) begin
                rd_word_d[i*BYTEW +: BYTEW] = datain[i*BYTEW +: BYTEW];
            end
        end
    end

`ifdef DPRAM_PARITY_EN
    logic [LANES-1:0] par_mem [DEPTH];
    logic [LANES-1:0] par_rd;

    always_ff @(posedge clk) begin
        if (!reset) begin
            for (int i = 0; i < LANES; i++) begin
                if (mem_lane_en[i]) begin
                    par_mem[mem_addr][i] <= (^mem_wdata[i*BYTEW +: BYTEW]) ^ mem_flip[i];
                end
            end
        end
    end

    always_comb begin
        par_rd = par_mem[raddr];
        perr_d = '0;
        for (int i = 0; i < LANES; i++) begin
            if (fwd && be[i]) begin
                par_rd[i] = (^datain[i*BYTEW +: BYTEW]) ^ wr_par_flip[i];
            end
            perr_d[i] = (^rd_word_d[i*BYTEW +: BYTEW]) ^ par_rd[i];
        end
    end
`else
    logic unused_flip;
    assign unused_flip = ^mem_flip;
    assign perr_d      = '0;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            dataout_q <= '0;
            valid_q   <= 1'b0;
            perr_q    <= '0;
        end else if ((state_q == ST_RUN) && rd_en) begin
            dataout_q <= rd_word_d;
            valid_q   <= 1'b1;
            perr_q    <= perr_d;
        end else begin
            valid_q   <= 1'b0;
        end
    end

    assign dataout       = dataout_q;
    assign dataout_valid = valid_q;
    assign parity_err    = perr_q;

endmodule

// File: tb/tb_dpram_be_init.sv
// Directed self-checking bench for dpram_be_init (default 32x32, 4 lanes).
// Define DPRAM_PARITY_EN for both RTL and bench to exercise the parity path.
module tb_dpram_be_init;

    logic        clk = 1'b0;
    logic        reset;
    logic [4:0]  raddr;
    logic        rd_en;
    logic [31:0] dataout;
    logic        dataout_valid;
    logic [4:0]  waddr;
    logic [31:0] datain;
    logic        we;
    logic [3:0]  be;
    logic [3:0]  wr_par_flip;
    logic [3:0]  parity_err;
    logic        init_busy;

    int n_checks = 0;
    int n_fails  = 0;

    always #5 clk = ~clk;

    dpram_be_init dut (
        .clk           (clk),
        .reset         (reset),
        .raddr         (raddr),
        .rd_en         (rd_en),
        .dataout       (dataout),
        .dataout_valid (dataout_valid),
        .waddr         (waddr),
        .datain        (datain),
        .we            (we),
        .be            (be),
        .wr_par_flip   (wr_par_flip),
        .parity_err    (parity_err),
        .init_busy     (init_busy)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [4:0] a, input logic [31:0] d, input logic [3:0] b,
                      input logic [3:0] f);
        we = 1'b1; waddr = a; datain = d; be = b; wr_par_flip = f;
        tick();
        we = 1'b0; be = 4'h0; wr_par_flip = 4'h0;
    endtask

    task automatic rd(input string tag, input logic [4:0] a, input logic [31:0] exp);
        rd_en = 1'b1; raddr = a;
        tick();
        rd_en = 1'b0;
        check({tag, "_valid"}, 64'(dataout_valid), 64'd1);
        check({tag, "_data"}, 64'(dataout), 64'(exp));
    endtask

    // Counts sampled cycles with init_busy high; stimulus inputs are left as driven.
    task automatic count_busy(input string tag, input logic chk_valid);
        int n = 0;
        while (init_busy === 1'b1 && n < 100) begin
            if (chk_valid) check({tag, "_valid_low"}, 64'(dataout_valid), 64'd0);
            n++;
            tick();
        end
        check({tag, "_busy_cycles"}, 64'(n), 64'd32);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick();
        reset = 1'b0;
    endtask

    localparam logic [3:0] PERR_EXP_STORED =
`ifdef DPRAM_PARITY_EN
        4'b0010;
`else
        4'b0000;
`endif
    localparam logic [3:0] PERR_EXP_FWD =
`ifdef DPRAM_PARITY_EN
        4'b0001;
`else
        4'b0000;
`endif

    initial begin
        reset = 1'b0; rd_en = 1'b0; raddr = '0; waddr = '0; datain = '0;
        we = 1'b0; be = '0; wr_par_flip = '0;
        #1;

        // Reset state and sweep length.
        do_reset();
        check("rst_dataout", 64'(dataout), 64'd0);
        check("rst_valid", 64'(dataout_valid), 64'd0);
        check("rst_parity_err", 64'(parity_err), 64'd0);
        check("rst_init_busy", 64'(init_busy), 64'd1);
        count_busy("init0", 1'b1);

        for (int a = 0; a < 32; a++) begin
            rd($sformatf("zero_a%0d", a), 5'(a), 32'h0);
        end

        // Byte-enable merge.
        wr(5'd3, 32'hAABBCCDD, 4'b1111, 4'h0);
        wr(5'd3, 32'h11223344, 4'b0101, 4'h0);
        rd("be_merge", 5'd3, 32'hAA22CC44);
        wr(5'd3, 32'h99999999, 4'b0000, 4'h0);
        rd("be_zero_noop", 5'd3, 32'hAA22CC44);

        // Write-first forwarding on same address.
        wr(5'd7, 32'h12345678, 4'b1111, 4'h0);
        rd_en = 1'b1; raddr = 5'd7;
        we = 1'b1; waddr = 5'd7; datain = 32'hFFFFFFFF; be = 4'b1100;
        tick();
        rd_en = 1'b0; we = 1'b0; be = 4'h0;
        check("fwd_data", 64'(dataout), 64'hFFFF5678);
        check("fwd_valid", 64'(dataout_valid), 64'd1);
        rd("fwd_after", 5'd7, 32'hFFFF5678);

        // Different addresses are independent.
        rd_en = 1'b1; raddr = 5'd3;
        we = 1'b1; waddr = 5'd20; datain = 32'h0BADF00D; be = 4'b1111;
        tick();
        rd_en = 1'b0; we = 1'b0; be = 4'h0;
        check("indep_read", 64'(dataout), 64'hAA22CC44);
        rd("indep_write", 5'd20, 32'h0BADF00D);

        // Back-to-back reads then idle.
        wr(5'd12, 32'hCAFEBABE, 4'b1111, 4'h0);
        tick();
        check("idle_valid", 64'(dataout_valid), 64'd0);
        rd_en = 1'b1; raddr = 5'd3;
        tick();
        check("b2b0_valid", 64'(dataout_valid), 64'd1);
        check("b2b0_data", 64'(dataout), 64'hAA22CC44);
        raddr = 5'd7;
        tick();
        check("b2b1_valid", 64'(dataout_valid), 64'd1);
        check("b2b1_data", 64'(dataout), 64'hFFFF5678);
        raddr = 5'd12;
        tick();
        check("b2b2_valid", 64'(dataout_valid), 64'd1);
        check("b2b2_data", 64'(dataout), 64'hCAFEBABE);
        rd_en = 1'b0; raddr = 5'd3;
        tick();
        check("b2b_idle_valid", 64'(dataout_valid), 64'd0);
        check("b2b_hold_data", 64'(dataout), 64'hCAFEBABE);
        tick();
        check("b2b_hold2_data", 64'(dataout), 64'hCAFEBABE);

        // Parity: stored flip and forwarded flip.
        wr(5'd9, 32'h0F0F0F0F, 4'b1111, 4'b0010);
        rd("par_stored", 5'd9, 32'h0F0F0F0F);
        check("par_stored_err", 64'(parity_err), 64'(PERR_EXP_STORED));
        rd("par_clean", 5'd3, 32'hAA22CC44);
        check("par_clean_err", 64'(parity_err), 64'd0);
        rd_en = 1'b1; raddr = 5'd10;
        we = 1'b1; waddr = 5'd10; datain = 32'h01010101; be = 4'b1111; wr_par_flip = 4'b0001;
        tick();
        rd_en = 1'b0; we = 1'b0; be = 4'h0; wr_par_flip = 4'h0;
        check("par_fwd_data", 64'(dataout), 64'h01010101);
        check("par_fwd_err", 64'(parity_err), 64'(PERR_EXP_FWD));

        // Reset in RUN re-zeroes the array; inputs are ignored during the sweep.
        wr(5'd5, 32'hDEADBEEF, 4'b1111, 4'h0);
        rd("pre_rst_a5", 5'd5, 32'hDEADBEEF);
        do_reset();
        check("rerun_busy", 64'(init_busy), 64'd1);
        check("rerun_dataout", 64'(dataout), 64'd0);
        we = 1'b1; waddr = 5'd6; datain = 32'h5A5A5A5A; be = 4'b1111; rd_en = 1'b1; raddr = 5'd6;
        count_busy("init_run_rst", 1'b1);
        we = 1'b0; be = 4'h0; rd_en = 1'b0;
        rd("post_rst_a5", 5'd5, 32'h0);
        rd("post_rst_a6", 5'd6, 32'h0);
        rd("post_rst_a9", 5'd9, 32'h0);
        check("post_rst_perr", 64'(parity_err), 64'd0);

        // Reset mid-sweep restarts the count.
        do_reset();
        for (int i = 0; i < 10; i++) tick();
        check("mid_busy", 64'(init_busy), 64'd1);
        do_reset();
        count_busy("init_mid_rst", 1'b0);
        rd("mid_rst_a31", 5'd31, 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation time limit reached");
        $fatal(1, "timeout");
    end

endmodule
